// File: rtl/ddr3_app_master.sv
`default_nettype none
// ============================================================================
// ddr3_app_master
// MIG DDR3 app-interface initiator: moves 64-bit words as two 32-bit beats.
// Optional stall counter built when DDR_APP_MASTER_STATS_EN is defined.
// Revision: 1.0
// ============================================================================
module ddr3_app_master #(
    parameter int pADDR_WIDTH      = 30,
    parameter int pCOUNT_WIDTH     = 16,
    parameter int pMAX_OUTSTANDING = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    init_calib_complete,
    input  logic                    cmd_start,
    input  logic                    cmd_read,
    input  logic [pADDR_WIDTH-1:0]  cmd_addr,
    input  logic [pCOUNT_WIDTH-1:0] cmd_count,
    output logic                    busy,
    output logic                    done,
    output logic                    err_unexpected,
    input  logic [63:0]             wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [63:0]             rd_data,
    output logic                    rd_valid,
    output logic [pADDR_WIDTH-1:0]  app_addr,
    output logic [2:0]              app_cmd,
    output logic                    app_en,
    output logic [31:0]             app_wdf_data,
    output logic                    app_wdf_wren,
    output logic                    app_wdf_end,
    input  logic                    app_rdy,
    input  logic                    app_wdf_rdy,
    input  logic [31:0]             app_rd_data,
    input  logic                    app_rd_data_valid,
    input  logic                    app_rd_data_end,
    output logic [31:0]             stall_count
);

    localparam int                      c_OUT_W     = $clog2(pMAX_OUTSTANDING + 1);
    localparam logic [c_OUT_W-1:0]      c_MAX_OUT   = c_OUT_W'(pMAX_OUTSTANDING);
    localparam logic [c_OUT_W-1:0]      c_OUT_ONE   = c_OUT_W'(1);
    localparam logic [pADDR_WIDTH-1:0]  c_ADDR_STEP = pADDR_WIDTH'(8);
    localparam logic [pADDR_WIDTH-1:0]  c_ADDR_MASK = ~pADDR_WIDTH'(7);
    localparam logic [pCOUNT_WIDTH-1:0] c_CNT_ONE   = pCOUNT_WIDTH'(1);
    localparam logic [2:0]              c_CMD_WR    = 3'b000;
    localparam logic [2:0]              c_CMD_RD    = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_B1    = 3'd1,
        S_WR_B2    = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_DRAIN = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [pADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [pCOUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [c_OUT_W-1:0]      outstanding_q, outstanding_d;
    logic                    half_pending_q, half_pending_d;
    logic [31:0]             upper_q, upper_d;
    logic [31:0]             wr_lo_q, wr_lo_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [63:0]             rd_data_q, rd_data_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    logic                    w_accept;
    logic                    w_issue_rd;
    logic                    w_ret_done;
    logic                    w_err_set;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        remaining_d    = remaining_q;
        wr_lo_d        = wr_lo_q;
        w_accept       = 1'b0;
        w_issue_rd     = 1'b0;
        app_en         = 1'b0;
        app_cmd        = 3'b000;
        app_addr       = '0;
        app_wdf_data   = 32'd0;
        app_wdf_wren   = 1'b0;
        app_wdf_end    = 1'b0;
        wr_ready       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_start && init_calib_complete) begin
                    w_accept    = 1'b1;
                    addr_d      = cmd_addr & c_ADDR_MASK;
                    remaining_d = cmd_count;
                    if (cmd_count == '0) begin
                        state_d = S_DONE;
                    end else if (cmd_read) begin
                        state_d = S_RD_ISSUE;
                    end else begin
                        state_d = S_WR_B1;
                    end
                end
            end
            S_WR_B1: begin
                if (wr_valid && app_rdy && app_wdf_rdy) begin
                    app_en       = 1'b1;
                    app_wdf_wren = 1'b1;
                    app_cmd      = c_CMD_WR;
                    app_addr     = addr_q;
                    app_wdf_data = wr_data[63:32];
                    wr_ready     = 1'b1;
                    wr_lo_d      = wr_data[31:0];
                    state_d      = S_WR_B2;
                end
            end
            S_WR_B2: begin
                if (app_rdy && app_wdf_rdy) begin
                    app_en       = 1'b1;
                    app_wdf_wren = 1'b1;
                    app_wdf_end  = 1'b1;
                    app_cmd      = c_CMD_WR;
                    app_addr     = addr_q;
                    app_wdf_data = wr_lo_q;
                    addr_d       = addr_q + c_ADDR_STEP;
                    remaining_d  = remaining_q - c_CNT_ONE;
                    state_d      = (remaining_q == c_CNT_ONE) ? S_DONE : S_WR_B1;
                end
            end
            S_RD_ISSUE: begin
                if ((outstanding_q < c_MAX_OUT) && app_rdy) begin
                    app_en      = 1'b1;
                    app_cmd     = c_CMD_RD;
                    app_addr    = addr_q;
                    w_issue_rd  = 1'b1;
                    addr_d      = addr_q + c_ADDR_STEP;
                    remaining_d = remaining_q - c_CNT_ONE;
                    if (remaining_q == c_CNT_ONE) begin
                        state_d = S_RD_DRAIN;
                    end
                end
            end
            S_RD_DRAIN: begin
                if (outstanding_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Return path runs in every state so stray beats are always flagged.
    always_comb begin
        half_pending_d = half_pending_q;
        upper_d        = upper_q;
        rd_valid_d     = 1'b0;
        rd_data_d      = rd_data_q;
        w_err_set      = 1'b0;
        w_ret_done     = 1'b0;
        if (app_rd_data_valid) begin
            if (outstanding_q == '0) begin
                w_err_set = 1'b1;
            end
            if (app_rd_data_end) begin
                if (!half_pending_q) begin
                    w_err_set = 1'b1;
                end
                rd_valid_d     = 1'b1;
                rd_data_d      = {upper_q, app_rd_data};
                half_pending_d = 1'b0;
                w_ret_done     = (outstanding_q != '0);
            end else begin
                if (half_pending_q) begin
                    w_err_set = 1'b1;
                end
                upper_d        = app_rd_data;
                half_pending_d = 1'b1;
            end
        end

        case ({w_issue_rd, w_ret_done})
            2'b10:   outstanding_d = outstanding_q + c_OUT_ONE;
            2'b01:   outstanding_d = outstanding_q - c_OUT_ONE;
            default: outstanding_d = outstanding_q;
        endcase

        err_d  = (err_q && !w_accept) || w_err_set;
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            remaining_q    <= '0;
            outstanding_q  <= '0;
            half_pending_q <= 1'b0;
            upper_q        <= 32'd0;
            wr_lo_q        <= 32'd0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= 64'd0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            remaining_q    <= remaining_d;
            outstanding_q  <= outstanding_d;
            half_pending_q <= half_pending_d;
            upper_q        <= upper_d;
            wr_lo_q        <= wr_lo_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err_unexpected = err_q;
    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;

`ifdef DDR_APP_MASTER_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic        w_stall;

    // A stall is a cycle where a beat/command is ready to go but the MIG refuses it.
    always_comb begin
        case (state_q)
            S_WR_B1:    w_stall = wr_valid && !(app_rdy && app_wdf_rdy);
            S_WR_B2:    w_stall = !(app_rdy && app_wdf_rdy);
            S_RD_ISSUE: w_stall = (outstanding_q < c_MAX_OUT) && !app_rdy;
            default:    w_stall = 1'b0;
        endcase
        stall_d = stall_q;
        if (w_accept) begin
            stall_d = 32'd0;
        end else if (w_stall && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr3_app_master.sv
`default_nettype none
// ============================================================================
// tb_ddr3_app_master
// Scoreboard bench for ddr3_app_master with a small app-interface memory model.
// Revision: 1.0
// ============================================================================
module tb_ddr3_app_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        init_calib_complete;
    logic        cmd_start;
    logic        cmd_read;
    logic [29:0] cmd_addr;
    logic [15:0] cmd_count;
    logic        busy;
    logic        done;
    logic        err_unexpected;
    logic [63:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic [29:0] app_addr;
    logic [2:0]  app_cmd;
    logic        app_en;
    logic [31:0] app_wdf_data;
    logic        app_wdf_wren;
    logic        app_wdf_end;
    logic        app_rdy;
    logic        app_wdf_rdy;
    logic [31:0] app_rd_data;
    logic        app_rd_data_valid;
    logic        app_rd_data_end;
    logic [31:0] stall_count;

    ddr3_app_master #(
        .pADDR_WIDTH(30),
        .pCOUNT_WIDTH(16),
        .pMAX_OUTSTANDING(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .init_calib_complete(init_calib_complete),
        .cmd_start(cmd_start), .cmd_read(cmd_read), .cmd_addr(cmd_addr), .cmd_count(cmd_count),
        .busy(busy), .done(done), .err_unexpected(err_unexpected),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [63:0] mem [int];
    logic [29:0] rdq [$];
    logic [63:0] expq [$];
    logic [63:0] wq [$];

    int          done_cnt  = 0;
    int          en_cnt    = 0;
    int          rd_issued = 0;
    int          stall_exp = 0;
    int          wr_left   = 0;
    logic        wr_active = 1'b0;
    logic [31:0] wr_hi;
    logic [29:0] wr_a;

    logic        hold_ret = 1'b0;
    logic        rnd_en   = 1'b0;
    logic        inj_req  = 1'b0;
    logic        ret_half = 1'b0;
    logic [31:0] inj_data;
    logic [63:0] ret_word;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic logic [63:0] memval(input int idx);
        if (mem.exists(idx)) return mem[idx];
        return {idx, ~idx};
    endfunction

    task automatic start(input logic rd, input logic [29:0] a, input logic [15:0] c);
        @(posedge clk); #1;
        cmd_start = 1'b1; cmd_read = rd; cmd_addr = a; cmd_count = c;
        @(posedge clk); #1;
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int base, input int budget);
        int n;
        n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done_cnt == base) begin
            bad++;
            $display("FAIL %s: got no done want done within %0d cycles", nm, budget);
        end
    endtask

    // Memory model, protocol monitor and scoreboard checker.
    initial begin
        forever begin
            @(negedge clk);
            if (app_en) begin
                en_cnt++;
                if (app_cmd == 3'b001) begin
                    rdq.push_back(app_addr);
                    rd_issued++;
                end else if (app_wdf_wren) begin
                    if (!app_wdf_end) begin
                        wr_hi = app_wdf_data;
                        wr_a  = app_addr;
                    end else begin
                        chk("wr_beat2_addr", {34'd0, app_addr}, {34'd0, wr_a});
                        mem[int'(wr_a >> 3)] = {wr_hi, app_wdf_data};
                    end
                end
            end
            if (wr_active) begin
                if (!(app_rdy && app_wdf_rdy)) stall_exp++;
                if (app_en && app_wdf_end) begin
                    wr_left--;
                    if (wr_left == 0) wr_active = 1'b0;
                end
            end
            if (done) done_cnt++;
            if (rd_valid) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_unexpected: got 0x%0h want no word", rd_data);
                end else begin
                    chk("rd_data", rd_data, expq.pop_front());
                end
            end
        end
    end

    // Read-return driver: two beats per command, upper half first.
    initial begin
        logic [29:0] ra;
        app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0; app_rd_data = 32'd0;
        forever begin
            @(posedge clk); #1;
            app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
            if (inj_req) begin
                app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1; app_rd_data = inj_data;
                inj_req = 1'b0;
            end else if (ret_half) begin
                app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1; app_rd_data = ret_word[31:0];
                ret_half = 1'b0;
            end else if (!hold_ret && rdq.size() > 0) begin
                ra = rdq.pop_front();
                ret_word = memval(int'(ra >> 3));
                app_rd_data_valid = 1'b1; app_rd_data_end = 1'b0; app_rd_data = ret_word[63:32];
                ret_half = 1'b1;
            end
        end
    end

    // Write-word feeder.
    initial begin
        wr_valid = 1'b0; wr_data = 64'd0;
        forever begin
            @(negedge clk);
            if (wr_ready && wq.size() > 0) void'(wq.pop_front());
            @(posedge clk); #1;
            wr_valid = (wq.size() > 0);
            wr_data  = (wq.size() > 0) ? wq[0] : 64'd0;
        end
    end

    // Ready stretches of 1..10 low cycles when enabled.
    initial begin
        int lo_a, lo_w;
        lo_a = 0; lo_w = 0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!rnd_en) begin
                app_rdy = 1'b1; app_wdf_rdy = 1'b1; lo_a = 0; lo_w = 0;
            end else begin
                if (lo_a == 0 && $urandom_range(0, 5) == 0) lo_a = int'($urandom_range(1, 10));
                if (lo_w == 0 && $urandom_range(0, 5) == 0) lo_w = int'($urandom_range(1, 10));
                app_rdy     = (lo_a == 0);
                app_wdf_rdy = (lo_w == 0);
                if (lo_a != 0) lo_a--;
                if (lo_w != 0) lo_w--;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, i0, n;
        logic [63:0] w64;
        cmd_start = 1'b0; cmd_read = 1'b0; cmd_addr = 30'd0; cmd_count = 16'd0;
        init_calib_complete = 1'b1; inj_data = 32'd0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {56'd0, app_en, app_wdf_wren, app_wdf_end, wr_ready, busy, done, rd_valid, err_unexpected}, 64'd0);
        chk("rst_app_addr", {34'd0, app_addr}, 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_stall", {32'd0, stall_count}, 64'd0);
        reset_n = 1'b1;

        // Write 4 words at an unaligned address.
        for (int i = 0; i < 4; i++) wq.push_back(64'h1111_2222_3333_4444 + 64'(i));
        d0 = done_cnt;
        start(1'b0, 30'h105, 16'd4);
        @(negedge clk);
        chk("first_app_en", {63'd0, app_en}, 64'd1);
        chk("first_app_addr", {34'd0, app_addr}, 64'h100);
        wait_done("wr4_done", d0, 200);
        repeat (3) @(negedge clk);
        chk("wr4_done_cnt", 64'(done_cnt - d0), 64'd1);
        for (int i = 0; i < 4; i++) chk("wr4_mem", memval(32 + i), 64'h1111_2222_3333_4444 + 64'(i));

        // Read them back.
        for (int i = 0; i < 4; i++) expq.push_back(64'h1111_2222_3333_4444 + 64'(i));
        d0 = done_cnt;
        start(1'b1, 30'h100, 16'd4);
        wait_done("rd4_done", d0, 200);
        repeat (3) @(negedge clk);
        chk("rd4_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("rd4_sb_empty", 64'(expq.size()), 64'd0);

        // Zero-length request.
        e0 = en_cnt;
        start(1'b0, 30'h200, 16'd0);
        @(negedge clk); chk("cnt0_done_c1", {63'd0, done}, 64'd0);
        @(negedge clk); chk("cnt0_done_c2", {63'd0, done}, 64'd1);
        @(negedge clk); chk("cnt0_done_c3", {63'd0, done}, 64'd0);
        repeat (3) @(negedge clk);
        chk("cnt0_no_app_en", 64'(en_cnt - e0), 64'd0);

        // 64 writes under random ready stalls, then readback.
        for (int i = 0; i < 64; i++) wq.push_back({32'hC0DE_0000 + 32'(i), 32'h0000_BEEF ^ 32'(i << 8)});
        rnd_en = 1'b1;
        stall_exp = 0;
        wr_left = 64;
        d0 = done_cnt;
        start(1'b0, 30'h4000, 16'd64);
        wr_active = 1'b1;
        wait_done("wr64_done", d0, 3000);
        rnd_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("wr64_all_beats", 64'(wr_left), 64'd0);
`ifdef DDR_APP_MASTER_STATS_EN
        chk("stall_count", {32'd0, stall_count}, 64'(stall_exp));
`else
        chk("stall_count_off", {32'd0, stall_count}, 64'd0);
`endif
        for (int i = 0; i < 64; i++) expq.push_back({32'hC0DE_0000 + 32'(i), 32'h0000_BEEF ^ 32'(i << 8)});
        d0 = done_cnt;
        start(1'b1, 30'h4000, 16'd64);
        wait_done("rd64_done", d0, 1000);
        repeat (3) @(negedge clk);
        chk("rd64_sb_empty", 64'(expq.size()), 64'd0);

        // Outstanding limit with returns held back.
        hold_ret = 1'b1;
        i0 = rd_issued;
        for (int i = 0; i < 40; i++) expq.push_back(memval(32'h200 + i));
        d0 = done_cnt;
        start(1'b1, 30'h1000, 16'd40);
        repeat (40) @(negedge clk);
        chk("hold_issued", 64'(rd_issued - i0), 64'd16);
        repeat (10) @(negedge clk);
        chk("hold_issued_still", 64'(rd_issued - i0), 64'd16);
        chk("hold_app_en_low", {63'd0, app_en}, 64'd0);
        hold_ret = 1'b0;
        wait_done("hold_done", d0, 1000);
        repeat (3) @(negedge clk);
        chk("hold_total_issued", 64'(rd_issued - i0), 64'd40);
        chk("hold_sb_empty", 64'(expq.size()), 64'd0);

        // cmd_start ignored while calibration is incomplete.
        init_calib_complete = 1'b0;
        start(1'b1, 30'h100, 16'd1);
        @(negedge clk);
        chk("nocalib_busy", {63'd0, busy}, 64'd0);
        init_calib_complete = 1'b1;

        // Asynchronous reset in the middle of a read.
        hold_ret = 1'b1;
        i0 = rd_issued;
        start(1'b1, 30'h100, 16'd10);
        n = 0;
        while ((rd_issued - i0) < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midrd_issued5", 64'((rd_issued - i0) >= 5), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_ctrl", {56'd0, app_en, app_wdf_wren, app_wdf_end, wr_ready, busy, done, rd_valid, err_unexpected}, 64'd0);
        chk("midrst_app_addr", {34'd0, app_addr}, 64'd0);
        chk("midrst_app_cmd", {61'd0, app_cmd}, 64'd0);
        chk("midrst_stall", {32'd0, stall_count}, 64'd0);
        rdq.delete();
        ret_half = 1'b0;
        hold_ret = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        expq.push_back(64'h1111_2222_3333_4444);
        d0 = done_cnt;
        start(1'b1, 30'h100, 16'd1);
        @(negedge clk);
        chk("postrst_busy", {63'd0, busy}, 64'd1);
        wait_done("postrst_done", d0, 200);
        repeat (3) @(negedge clk);
        chk("postrst_sb_empty", 64'(expq.size()), 64'd0);

        // Stray end beat while idle.
        w64 = memval(32);
        inj_data = 32'hDEAD_BEEF;
        expq.push_back({w64[63:32], 32'hDEAD_BEEF});
        inj_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("inj_err_set", {63'd0, err_unexpected}, 64'd1);
        repeat (5) @(negedge clk);
        chk("inj_err_sticky", {63'd0, err_unexpected}, 64'd1);
        d0 = done_cnt;
        start(1'b0, 30'h0, 16'd0);
        @(negedge clk);
        chk("inj_err_cleared", {63'd0, err_unexpected}, 64'd0);
        wait_done("inj_clear_done", d0, 50);
        repeat (3) @(negedge clk);
        chk("inj_sb_empty", 64'(expq.size()), 64'd0);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
